// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands one byte at a time from NUM_REQ requesters
// to a single UART transmitter, tracking the transmitter's busy handshake.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned BUSY_TIMEOUT = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  output logic [2:0]             grant_id,
  output logic                   frame_done,
  output logic                   err_timeout
);

  localparam int unsigned IDW    = 3;
  localparam int unsigned MAXREQ = 8;
  localparam int unsigned BW     = 8;
  localparam int unsigned DATAW  = MAXREQ * BW;
  localparam int unsigned CNTW   = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  state_t            state;
  logic [IDW-1:0]    last;
  logic [CNTW-1:0]   wait_cnt;

  logic [MAXREQ-1:0] req_ext;
  logic [DATAW-1:0]  data_ext;
  logic              win_valid;
  logic [IDW-1:0]    win_idx;
  logic [IDW-1:0]    pos;
  logic [MAXREQ-1:0] win_onehot;

  // Zero-extend to the maximum requester count so indices are always 3 bits.
  assign req_ext    = MAXREQ'(req);
  assign data_ext   = DATAW'(req_data);
  assign win_onehot = MAXREQ'(1) << win_idx;

  // (base + off) mod NUM_REQ for off in 1..NUM_REQ.
  function automatic logic [IDW-1:0] next_pos(input logic [IDW-1:0] base,
                                              input logic [IDW:0]   off);
    logic [IDW:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= (IDW+1)'(NUM_REQ)) begin
      sum = sum - (IDW+1)'(NUM_REQ);
    end
    return sum[IDW-1:0];
  endfunction

  // Scan from farthest to nearest so the nearest requester after last wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    pos       = '0;
    for (int i = int'(NUM_REQ); i >= 1; i--) begin
      pos = next_pos(last, (IDW+1)'(i));
      if (req_ext[pos]) begin
        win_valid = 1'b1;
        win_idx   = pos;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ack         <= '0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      grant_id    <= '0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      wait_cnt    <= '0;
      last        <= IDW'(NUM_REQ - 1);
    end else begin
      ack         <= '0;
      tx_start    <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            tx_start <= 1'b1;
            ack      <= NUM_REQ'(win_onehot);
            tx_data  <= data_ext[{win_idx, 3'b000} +: BW];
            grant_id <= win_idx;
            last     <= win_idx;
            wait_cnt <= '0;
            state    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (wait_cnt == CNTW'(BUSY_TIMEOUT - 1)) begin
            // Transmitter never acknowledged the start pulse; give up on it.
            wait_cnt    <= wait_cnt + CNTW'(1);
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNTW'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            frame_done <= 1'b1;
            state      <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, BUSY_TIMEOUT=7).
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ      = 4;
  localparam int unsigned BUSY_TIMEOUT = 7;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [2:0]           grant_id;
  logic                 frame_done;
  logic                 err_timeout;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .frame_done  (frame_done),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    tx_busy  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_start(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int k = 0; k < 30 && !ok; k++) begin
      tick();
      n++;
      if (tx_start) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    int pulses;
    rst_n    = 1'b0;
    req      = 4'b1111;
    req_data = 32'h13121110;
    tx_busy  = 1'b0;
    tick();
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL reset_ack: got %b want 0000", ack); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    total++; if (grant_id !== 3'd0) begin bad++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    total++; if ({frame_done, err_timeout} !== 2'b00) begin bad++; $display("FAIL reset_pulses: got %b want 00", {frame_done, err_timeout}); end
    req   = '0;
    rst_n = 1'b1;
    pulses = 0;
    repeat (5) begin
      tick();
      if (tx_start || ack != 0 || frame_done || err_timeout) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL idle_no_pulses: got %0d want 0", pulses); end
  endtask

  task automatic test_single;
    int fd, st;
    do_reset();
    req_data[7:0] = 8'hA5;
    req = 4'b0001;
    tick();
    total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL single_tx_start: got %b want 1", tx_start); end
    total++; if (ack !== 4'b0001) begin bad++; $display("FAIL single_ack: got %b want 0001", ack); end
    total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL single_tx_data: got %h want a5", tx_data); end
    total++; if (grant_id !== 3'd0) begin bad++; $display("FAIL single_grant: got %0d want 0", grant_id); end
    req     = '0;
    tx_busy = 1'b1;
    fd = 0;
    st = 0;
    repeat (82) begin
      tick();
      if (frame_done) fd++;
      if (tx_start || ack != 0) st++;
    end
    total++; if (fd !== 0) begin bad++; $display("FAIL single_early_done: got %0d want 0", fd); end
    total++; if (st !== 0) begin bad++; $display("FAIL single_extra_start: got %0d want 0", st); end
    total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL single_data_hold: got %h want a5", tx_data); end
    tx_busy = 1'b0;
    tick();
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL single_frame_done: got %b want 1", frame_done); end
    tick();
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL single_done_width: got %b want 0", frame_done); end
    tick();
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_no_regrant: got %b want 0", tx_start); end
  endtask

  task automatic test_round_robin;
    bit ok;
    int n;
    logic [2:0] exp;
    do_reset();
    req_data = 32'h13121110;
    req      = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      exp = 3'(f % NUM_REQ);
      wait_start(ok, n);
      total++;
      if (!ok) begin
        bad++; $display("FAIL rr_start_%0d: got no tx_start want tx_start", f);
      end else begin
        total++; if (grant_id !== exp) begin bad++; $display("FAIL rr_grant_%0d: got %0d want %0d", f, grant_id, exp); end
        total++; if (tx_data !== 8'(8'h10 + exp)) begin bad++; $display("FAIL rr_data_%0d: got %h want %h", f, tx_data, 8'(8'h10 + exp)); end
        total++; if (ack !== 4'(1 << exp)) begin bad++; $display("FAIL rr_ack_%0d: got %b want %b", f, ack, 4'(1 << exp)); end
        total++; if (n !== ((f == 0) ? 1 : 3)) begin bad++; $display("FAIL rr_gap_%0d: got %0d want %0d", f, n, (f == 0) ? 1 : 3); end
      end
      tx_busy = 1'b1;
      tick();
      total++; if (ack !== 4'b0000) begin bad++; $display("FAIL rr_ack_width_%0d: got %b want 0000", f, ack); end
      repeat (2) tick();
      tx_busy = 1'b0;
    end
    req = '0;
    repeat (3) tick();
  endtask

  task automatic test_wrap;
    bit ok;
    int n;
    do_reset();
    req_data = 32'h13121110;
    req      = 4'b0100;
    wait_start(ok, n);
    total++; if (!ok || grant_id !== 3'd2) begin bad++; $display("FAIL wrap_first: got %0d want 2", grant_id); end
    req     = 4'b0101;
    tx_busy = 1'b1;
    tick();
    tx_busy = 1'b0;
    wait_start(ok, n);
    total++; if (!ok || grant_id !== 3'd0) begin bad++; $display("FAIL wrap_grant: got %0d want 0", grant_id); end
    total++; if (ack !== 4'b0001) begin bad++; $display("FAIL wrap_ack: got %b want 0001", ack); end
    total++; if (tx_data !== 8'h10) begin bad++; $display("FAIL wrap_data: got %h want 10", tx_data); end
    req     = '0;
    tx_busy = 1'b1;
    tick();
    tx_busy = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_timeout;
    int early;
    do_reset();
    req_data = 32'h13121110;
    tx_busy  = 1'b0;
    req      = 4'b0010;
    tick();
    total++; if (tx_start !== 1'b1 || ack !== 4'b0010) begin bad++; $display("FAIL to_start: got %b/%b want 1/0010", tx_start, ack); end
    early = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k < 7) begin
        if (err_timeout || tx_start) early++;
      end else begin
        total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_err_pulse: got %b want 1", err_timeout); end
        total++; if (frame_done !== 1'b0 || tx_start !== 1'b0) begin bad++; $display("FAIL to_side_pulses: got %b%b want 00", frame_done, tx_start); end
      end
    end
    total++; if (early !== 0) begin bad++; $display("FAIL to_early: got %0d want 0", early); end
    tick();
    total++; if (tx_start !== 1'b1 || grant_id !== 3'd1) begin bad++; $display("FAIL to_regrant: got %b/%0d want 1/1", tx_start, grant_id); end
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL to_err_width: got %b want 0", err_timeout); end
    req = '0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    req_data = 32'h13121110;
    req      = 4'b0100;
    tick();
    total++; if (grant_id !== 3'd2 || tx_data !== 8'h12) begin bad++; $display("FAIL rm_grant: got %0d/%h want 2/12", grant_id, tx_data); end
    req     = '0;
    tx_busy = 1'b1;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    total++; if ({tx_start, ack, frame_done, err_timeout} !== 7'b0) begin bad++; $display("FAIL rm_pulses: got %b want 0000000", {tx_start, ack, frame_done, err_timeout}); end
    total++; if (tx_data !== 8'h00 || grant_id !== 3'd0) begin bad++; $display("FAIL rm_regs: got %h/%0d want 00/0", tx_data, grant_id); end
    rst_n = 1'b1;
    req   = 4'b1111;
    tick();
    total++; if (tx_start !== 1'b1 || grant_id !== 3'd0 || ack !== 4'b0001) begin bad++; $display("FAIL rm_first_grant: got %b/%0d/%b want 1/0/0001", tx_start, grant_id, ack); end
    req     = '0;
    tx_busy = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_withdraw;
    bit ok;
    int n, ack1;
    do_reset();
    req_data = 32'h13121110;
    req      = 4'b0001;
    tick();
    total++; if (ack !== 4'b0001) begin bad++; $display("FAIL wd_ack0: got %b want 0001", ack); end
    req     = '0;
    tx_busy = 1'b1;
    repeat (2) tick();
    req  = 4'b0010;
    ack1 = 0;
    repeat (3) begin
      tick();
      if (ack[1]) ack1++;
    end
    req     = '0;
    tx_busy = 1'b0;
    repeat (6) begin
      tick();
      if (ack[1] || tx_start) ack1++;
    end
    total++; if (ack1 !== 0) begin bad++; $display("FAIL wd_no_ack1: got %0d want 0", ack1); end
    req = 4'b0100;
    wait_start(ok, n);
    total++; if (!ok || grant_id !== 3'd2 || ack !== 4'b0100) begin bad++; $display("FAIL wd_next_grant: got %0d/%b want 2/0100", grant_id, ack); end
    req = '0;
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    tx_busy  = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_withdraw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL provide parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL provide parameter BUSY_TIMEOUT, default 7, max cycles waiting for tx_busy rise (1..15).
REQ-003 SHALL provide port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide port req  input  NUM_REQ  per-requester level request; bit i held until ack[i].
REQ-006 SHALL provide port req_data  input  8*NUM_REQ  requester i byte at bits [8i+7:8i], stable while req[i]=1.
REQ-007 SHALL provide port ack  output  NUM_REQ  one-cycle pulse, byte of requester i accepted.
REQ-008 SHALL provide port tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-009 SHALL provide port tx_data  output  8  byte to the transmitter, valid with tx_start.
REQ-010 SHALL provide port tx_busy  input  1  transmitter busy flag.
REQ-011 SHALL provide port grant_id  output  3  index of last granted requester.
REQ-012 SHALL provide port frame_done  output  1  one-cycle pulse when the granted frame completes.
REQ-013 SHALL provide port err_timeout  output  1  one-cycle pulse when tx_busy never rose.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT_BUSY, WAIT_DONE, GAP; all outputs registered.
REQ-015 IDLE, req!=0: SHALL select winner round-robin, searching from (last+1) mod NUM_REQ upward with wrap.
REQ-016 On selection, next edge SHALL set tx_start=1, ack[win]=1, tx_data=req_data[win], grant_id=win, last=win, state->WAIT_BUSY.
REQ-017 tx_start and ack SHALL be high exactly one cycle; at most one ack bit high in any cycle.
REQ-018 tx_data and grant_id SHALL hold their value until the next grant.
REQ-019 IDLE, req=0: SHALL stay IDLE, no pulses.
REQ-020 WAIT_BUSY: SHALL clear a wait counter on entry and increment it each cycle tx_busy=0.
REQ-021 WAIT_BUSY, tx_busy=1: SHALL go to WAIT_DONE.
REQ-022 WAIT_BUSY, counter reaches BUSY_TIMEOUT with tx_busy=0: SHALL pulse err_timeout one cycle and go to IDLE; no frame_done.
REQ-023 WAIT_DONE, tx_busy=0: SHALL pulse frame_done one cycle and go to GAP; otherwise remain.
REQ-024 GAP: SHALL last exactly one cycle, ignore req, then go to IDLE (min two idle cycles between tx_start pulses after busy falls).
REQ-025 req changes outside IDLE SHALL be ignored; a req bit dropped before its ack SHALL be treated as withdrawn, no ack.
REQ-026 Single requester held continuously SHALL be regranted after every GAP; all-requesters-held SHALL grant 0,1,2,...,NUM_REQ-1,0 in order.
REQ-027 tx_busy=1 while in IDLE SHALL not block granting (transmitter discards; behaviour unchanged).

Reset
REQ-028 rst_n=0 at an edge SHALL force state=IDLE, ack=0, tx_start=0, tx_data=8'h00, grant_id=0, frame_done=0, err_timeout=0, wait counter=0, last=NUM_REQ-1 (requester 0 highest first).
REQ-029 Reset mid-frame SHALL abort without frame_done or err_timeout; first grant after release SHALL follow REQ-015 with last=NUM_REQ-1.

Verification
REQ-030 req=4'b0001, data0=8'hA5, transmitter model busy 1 cycle after start for 82 cycles -> tx_start+ack=0001 one cycle after req, tx_data=A5, frame_done once after busy falls.
REQ-031 req=4'b1111 held, data i=8'h10+i -> grant_id sequence 0,1,2,3,0; tx_data 10,11,12,13,10; one ack per frame.
REQ-032 Grant 2, then req=4'b0101 -> next grant 0 (wrap past 3 from last=2 finds none before 0).
REQ-033 tx_busy tied 0, req=4'b0010 -> tx_start once, err_timeout pulse 7 cycles after WAIT_BUSY entry, state IDLE, regrant to 1 on following cycle.
REQ-034 rst_n=0 for one cycle during WAIT_DONE -> all outputs at reset values next cycle, no frame_done; req=4'b1111 afterwards grants 0.
REQ-035 req[1] raised then dropped during another grant's WAIT_DONE -> no ack[1] ever issued.
